// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch sequencer feeding uart_tx (watchdog: UART_TX_FIFO_WDOG_EN)
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done,
    output logic              o_Wdog_Err
);

    if ((2 ** ADDR_W) != DEPTH || DEPTH < 2 || CLKS_PER_BIT < 1 || (11 * CLKS_PER_BIT) >= (2 ** 20))
    begin : g_param_check
        $error("uart_tx_fifo: inconsistent DEPTH/ADDR_W/CLKS_PER_BIT");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_DRAIN     = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              wr_accept;
    logic              pop;
    state_t            state;
    state_t            state_next;

    // Fullness is judged on the pre-edge count, so a simultaneous pop never frees a slot early.
    assign wr_accept = i_Wr_DV && (count != FULL_CNT);
    assign o_Count   = count;

`ifdef UART_TX_FIFO_WDOG_EN
    // The LAUNCH cycle and the expiry edge both count, so the error lands 11 bit-times after the DV edge.
    localparam logic [19:0] WDOG_LAST = 20'(11 * CLKS_PER_BIT - 2);

    logic [19:0] wdog_cnt;
    logic        wdog_expire;
    logic        wdog_err_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wdog_cnt   <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (state == S_LAUNCH)
                wdog_cnt <= '0;
            else if (state == S_WAIT_DONE)
                wdog_cnt <= wdog_cnt + 20'd1;
            wdog_err_q <= wdog_expire;
        end
    end

    assign o_Wdog_Err = wdog_err_q;
`else
    assign o_Wdog_Err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pop        = 1'b0;
`ifdef UART_TX_FIFO_WDOG_EN
        wdog_expire = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (count != '0 && !i_Tx_Active && !i_Tx_Done) begin
                    pop        = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: state_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (i_Tx_Done)
                    state_next = S_DRAIN;
`ifdef UART_TX_FIFO_WDOG_EN
                else if (wdog_cnt == WDOG_LAST) begin
                    wdog_expire = 1'b1;
                    state_next  = S_IDLE;
                end
`endif
            end
            // uart_tx ignores DV while Done is high, so relaunching before it clears drops a byte.
            S_DRAIN: begin
                if (!i_Tx_Done)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({wr_accept, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge i_Clock) begin
        if (wr_accept)
            mem[wr_ptr] <= i_Wr_Byte;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Empty    <= 1'b1;
            o_Full     <= 1'b0;
            o_Overflow <= 1'b0;
            o_Tx_DV    <= 1'b0;
            o_Tx_Byte  <= 8'h00;
        end else begin
            if (wr_accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                o_Tx_Byte <= mem[rd_ptr];
            end
            count      <= count_next;
            o_Empty    <= (count_next == '0);
            o_Full     <= (count_next == FULL_CNT);
            o_Overflow <= i_Wr_DV && !wr_accept;
            o_Tx_DV    <= pop;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo driving a behavioural uart_tx sink
module tb_uart_tx_fifo;

    localparam int CPB    = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_dv;
    logic [7:0]        wr_byte;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              wdog_err;
    logic              tx_active_in;
    logic              tx_done_in;
    logic              force_busy;
    logic              stub_sink;

    typedef enum logic [2:0] {M_IDLE, M_START, M_DATA, M_STOP, M_CLEAN} m_st_t;
    m_st_t       m_st     = M_IDLE;
    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;
    logic        m_serial = 1'b1;
    logic [7:0]  m_data   = 8'h00;
    logic [2:0]  m_idx    = 3'd0;
    int          m_cnt    = 0;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          cyc        = 0;
    int          dv_pulses  = 0;
    int          wdog_pulses = 0;
    logic [7:0]  launch_q[$];
    logic [7:0]  frame_q[$];

    always #5 clk = ~clk;

    assign tx_active_in = stub_sink ? 1'b0 : (m_active | force_busy);
    assign tx_done_in   = stub_sink ? 1'b0 : m_done;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (overflow),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active_in),
        .i_Tx_Done   (tx_done_in),
        .o_Wdog_Err  (wdog_err)
    );

    // Behavioural uart_tx: Done high for two cycles after the stop bit, DV ignored until it clears.
    always @(posedge clk) begin
        case (m_st)
            M_IDLE: begin
                m_serial <= 1'b1;
                m_done   <= 1'b0;
                m_cnt    <= 0;
                m_idx    <= 3'd0;
                if (tx_dv && !stub_sink) begin
                    m_active <= 1'b1;
                    m_data   <= tx_byte;
                    m_st     <= M_START;
                end
            end
            M_START: begin
                m_serial <= 1'b0;
                if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
                else begin m_cnt <= 0; m_st <= M_DATA; end
            end
            M_DATA: begin
                m_serial <= m_data[m_idx];
                if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
                else begin
                    m_cnt <= 0;
                    if (m_idx < 3'd7) m_idx <= m_idx + 3'd1;
                    else begin m_idx <= 3'd0; m_st <= M_STOP; end
                end
            end
            M_STOP: begin
                m_serial <= 1'b1;
                if (m_cnt < CPB - 1) m_cnt <= m_cnt + 1;
                else begin m_cnt <= 0; m_done <= 1'b1; m_active <= 1'b0; m_st <= M_CLEAN; end
            end
            default: begin
                m_done <= 1'b1;
                m_st   <= M_IDLE;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        launch_q.push_back(b);
        frame_q.push_back(b);
    endtask

    task automatic wait_dv(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (tx_dv === 1'b1) return;
            @(negedge clk);
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_wdog(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (wdog_err === 1'b1) return;
            @(negedge clk);
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (frame_q.size() == 0 && launch_q.size() == 0 && m_st == M_IDLE && !m_done) begin
                tick(4);
                return;
            end
        end
        check({tag, "_drain_timeout"}, 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dv"},       tx_dv,    0);
        check({tag, "_byte"},     tx_byte,  8'h00);
        check({tag, "_count"},    count,    0);
        check({tag, "_empty"},    empty,    1);
        check({tag, "_full"},     full,     0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_wdog"},     wdog_err, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (wdog_err === 1'b1) wdog_pulses++;
    end

    // Launch monitor: byte order, single-cycle DV and minimum frame spacing.
    initial begin : dv_mon
        logic prev;
        int   last;
        prev = 1'b0;
        last = -1000;
        forever begin
            @(negedge clk);
            if (rst_n && tx_dv) begin
                check("dv_width", prev, 0);
                check("launch_gap", ((cyc - last) >= (10 * CPB + 3)), 1);
                if (launch_q.size() > 0) check("dv_byte", tx_byte, launch_q.pop_front());
                else                     check("dv_unexpected", 1, 0);
                last = cyc;
                dv_pulses++;
            end
            prev = rst_n && tx_dv;
        end
    end

    // Serial receiver: samples each bit half a cycle after it starts and compares the whole frame.
    initial forever begin
        @(negedge clk);
        if (m_serial === 1'b0) begin
            logic [9:0] bits;
            logic [7:0] e;
            bits[0] = 1'b0;
            for (int k = 1; k < 10; k++) begin
                repeat (CPB) @(negedge clk);
                bits[k] = m_serial;
            end
            if (frame_q.size() > 0) begin
                e = frame_q.pop_front();
                check("frame", bits, {1'b1, e, 1'b0});
            end else begin
                check("frame_unexpected", 1, 0);
            end
        end
    end

    initial begin
        logic [7:0] burst [3];
        int         t_l;
        int         t_w;
        int         dv_before;
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;

        rst_n = 1'b0; wr_dv = 1'b0; wr_byte = 8'h00; force_busy = 1'b0; stub_sink = 1'b0;
        tick(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Single byte into an empty FIFO
        wr_dv = 1'b1; wr_byte = 8'hA5; push(8'hA5);
        tick();
        wr_dv = 1'b0;
        check("t1_dv_early", tx_dv, 0);
        check("t1_count", count, 1);
        check("t1_empty_low", empty, 0);
        tick();
        check("t1_dv", tx_dv, 1);
        check("t1_byte", tx_byte, 8'hA5);
        check("t1_empty_back", empty, 1);
        drain("t1", 200);

        // Burst of three held back by a busy sink, then released
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_dv = 1'b1; wr_byte = burst[i]; push(burst[i]);
            tick();
            check("t2_count_up", count, i + 1);
        end
        wr_dv = 1'b0;
        force_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_dv("t2_dv", 120);
            check("t2_count_down", count, 2 - i);
            tick();
        end
        drain("t2", 400);

        // Fill to DEPTH, then one dropped write
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_dv = 1'b1; wr_byte = 8'h40 + 8'(i); push(8'h40 + 8'(i));
            tick();
            check("t3_ovf_quiet", overflow, 0);
        end
        check("t3_full", full, 1);
        check("t3_count_full", count, DEPTH);
        wr_byte = 8'hFF;
        tick();
        wr_dv = 1'b0;
        check("t3_ovf", overflow, 1);
        check("t3_count_hold", count, DEPTH);
        tick();
        check("t3_ovf_once", overflow, 0);
        check("t3_count_after", count, DEPTH);
        force_busy = 1'b0;
        drain("t3", 1200);

        // Write on the same edge as a pop with five queued
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_dv = 1'b1; wr_byte = 8'h50 + 8'(i); push(8'h50 + 8'(i));
            tick();
        end
        check("t4_count_pre", count, 5);
        force_busy = 1'b0;
        wr_byte = 8'h5C; push(8'h5C);
        tick();
        wr_dv = 1'b0;
        check("t4_dv", tx_dv, 1);
        check("t4_count_same", count, 5);
        drain("t4", 500);

        // Asynchronous reset mid-frame with four bytes queued
        for (int i = 0; i < 5; i++) begin
            wr_dv = 1'b1; wr_byte = 8'h70 + 8'(i); push(8'h70 + 8'(i));
            tick();
        end
        wr_dv = 1'b0;
        check("t5_count", count, 4);
        tick(20);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_async");
        launch_q.delete();
        while (frame_q.size() > 1) void'(frame_q.pop_back());
        dv_before = dv_pulses;
        tick(3);
        rst_n = 1'b1;
        tick(150);
        check("t5_no_dv", dv_pulses - dv_before, 0);
        wr_dv = 1'b1; wr_byte = 8'h3C; push(8'h3C);
        tick();
        wr_dv = 1'b0;
        drain("t5", 200);

`ifdef UART_TX_FIFO_WDOG_EN
        // Sink never reports Done: watchdog recovers and the next byte launches
        stub_sink = 1'b1;
        wr_dv = 1'b1; wr_byte = 8'h66; launch_q.push_back(8'h66);
        tick();
        wr_byte = 8'h77; launch_q.push_back(8'h77);
        tick();
        wr_dv = 1'b0;
        wait_dv("t6_dv", 10);
        t_l = cyc;
        wait_wdog("t6_wdog", 100);
        check("t6_wdog_latency", cyc - t_l, 11 * CPB);
        t_w = cyc;
        tick();
        wait_dv("t6_next", 10);
        check("t6_relaunch", cyc - t_w, 1);
        tick();
        wait_wdog("t6_wdog2", 100);
        tick(2);
        stub_sink = 1'b0;
        tick(5);
        check("t6_wdog_pulses", wdog_pulses, 2);
`else
        t_l = 0; t_w = 0;
        check("wdog_quiet", wdog_pulses + t_l + t_w, 0);
`endif

        check("launch_q_empty", launch_q.size(), 0);
        check("frame_q_empty", frame_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
